// File: rtl/snitch_tcdm_bank_rsp_adapter_pkg.sv
// Shared types for the TCDM bank response adapter. reqrsp_pkg carries the AMO opcode;
// snitch_tcdm_adapter_pkg carries sizing helpers.
`timescale 1ns/1ps
package reqrsp_pkg;
  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;
endpackage

package snitch_tcdm_adapter_pkg;
  localparam int unsigned DefaultRspDepth = 2;

  // Occupancy counter must hold the value Depth itself, not just Depth-1.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/snitch_tcdm_bank_rsp_adapter_if.sv
// Request, response and shim-side signal bundle of the TCDM bank response adapter.
`timescale 1ns/1ps
interface snitch_tcdm_bank_rsp_adapter_if #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned StrbWidth    = DataWidth / 8,
  parameter int unsigned CoreIDWidth  = 1,
  parameter int unsigned UserWidth    = 8
) ();
  import reqrsp_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [AddrMemWidth-1:0] req_addr;
  logic                    req_write;
  amo_op_e                 req_amo;
  logic [DataWidth-1:0]    req_wdata;
  logic [StrbWidth-1:0]    req_wstrb;
  logic [CoreIDWidth-1:0]  req_core_id;
  logic                    req_is_core;
  logic                    req_dma;
  logic [UserWidth-1:0]    req_user;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic [UserWidth-1:0]    rsp_user;

  logic                    shim_valid;
  logic                    shim_ready;
  logic                    shim_dma;
  logic [AddrMemWidth-1:0] shim_addr;
  amo_op_e                 shim_amo;
  logic                    shim_write;
  logic [DataWidth-1:0]    shim_wdata;
  logic [StrbWidth-1:0]    shim_wstrb;
  logic [CoreIDWidth-1:0]  shim_core_id;
  logic                    shim_is_core;
  logic [DataWidth-1:0]    shim_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_amo, req_wdata, req_wstrb,
           req_core_id, req_is_core, req_dma, req_user, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_user
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_amo, req_wdata, req_wstrb,
           req_core_id, req_is_core, req_dma, req_user, rsp_ready,
           shim_ready, shim_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_user,
           shim_valid, shim_dma, shim_addr, shim_amo, shim_write, shim_wdata,
           shim_wstrb, shim_core_id, shim_is_core
  );

  modport shim (
    input  shim_valid, shim_dma, shim_addr, shim_amo, shim_write, shim_wdata,
           shim_wstrb, shim_core_id, shim_is_core,
    output shim_ready, shim_rdata
  );
endinterface

// File: rtl/snitch_tcdm_rsp_fifo.sv
// Circular response buffer with occupancy counter.
// SNITCH_TCDM_RSP_BYPASS_EN: when empty, the incoming entry is presented combinationally.
`timescale 1ns/1ps
module snitch_tcdm_rsp_fifo
  import snitch_tcdm_adapter_pkg::*;
#(
  parameter int unsigned Depth = DefaultRspDepth,
  parameter type         entry_t = logic,
  parameter int unsigned CntW  = cnt_width(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_valid,
  input  entry_t          push_data,
  output logic            pop_valid,
  input  logic            pop_ready,
  output entry_t          pop_data,
  output logic [CntW-1:0] cnt
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            empty, do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;
  assign do_pop = !empty & pop_ready;

`ifdef SNITCH_TCDM_RSP_BYPASS_EN
  // An entry consumed on arrival never occupies a slot.
  assign pop_valid = !empty | push_valid;
  assign pop_data  = empty ? push_data : mem_q[rptr_q];
  assign do_push   = push_valid & !(empty & pop_ready);
`else
  assign pop_valid = !empty;
  assign pop_data  = mem_q[rptr_q];
  assign do_push   = push_valid;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_valid && (cnt_q == CntW'(Depth))));
endmodule

// File: rtl/snitch_tcdm_bank_rsp_adapter.sv
// Drives the bank AMO/RMW shim from a valid/ready request stream and returns in-order responses.
// SNITCH_TCDM_RSP_BYPASS_EN selects the 1-cycle response path inside the FIFO.
`timescale 1ns/1ps
module snitch_tcdm_bank_rsp_adapter
  import reqrsp_pkg::*;
  import snitch_tcdm_adapter_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned StrbWidth    = DataWidth / 8,
  parameter int unsigned CoreIDWidth  = 1,
  parameter int unsigned UserWidth    = 8,
  parameter int unsigned RspDepth     = DefaultRspDepth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  snitch_tcdm_bank_rsp_adapter_if.slave  bus,
  output logic                           busy_o
);
  localparam int unsigned CntW = cnt_width(RspDepth);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [UserWidth-1:0] user;
  } rsp_entry_t;

  logic                 inflight_q;
  logic [UserWidth-1:0] user_q;
  logic [CntW-1:0]      fifo_cnt_q;
  logic                 credit_ok, accept;
  rsp_entry_t           push_entry, pop_entry;

  // Credit counts registered state only, so a same-cycle pop frees nothing yet.
  assign credit_ok = (32'(fifo_cnt_q) + 32'(inflight_q)) < RspDepth;

  assign bus.shim_valid   = bus.req_valid & credit_ok;
  assign bus.req_ready    = bus.shim_ready & credit_ok;
  assign accept           = bus.req_valid & bus.req_ready;
  assign bus.shim_dma     = bus.req_dma;
  assign bus.shim_addr    = bus.req_addr;
  assign bus.shim_amo     = bus.req_amo;
  assign bus.shim_write   = bus.req_write;
  assign bus.shim_wdata   = bus.req_wdata;
  assign bus.shim_wstrb   = bus.req_wstrb;
  assign bus.shim_core_id = bus.req_core_id;
  assign bus.shim_is_core = bus.req_is_core;

  // Stage N: acceptance marks one response in flight and holds its tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_q <= 1'b0;
    else         inflight_q <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) user_q <= bus.req_user;
  end

  // Stage N+1: shim read data is valid now and joins its tag in the FIFO.
  assign push_entry = '{data: bus.shim_rdata, user: user_q};

  snitch_tcdm_rsp_fifo #(
    .Depth   (RspDepth),
    .entry_t (rsp_entry_t),
    .CntW    (CntW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_valid (inflight_q),
    .push_data  (push_entry),
    .pop_valid  (bus.rsp_valid),
    .pop_ready  (bus.rsp_ready),
    .pop_data   (pop_entry),
    .cnt        (fifo_cnt_q)
  );

  assign bus.rsp_rdata = pop_entry.data;
  assign bus.rsp_user  = pop_entry.user;
  assign busy_o        = inflight_q | (fifo_cnt_q != '0);

  assert property (@(posedge clk_i)
    ($bits(bus.req_addr) == AddrMemWidth) && ($bits(bus.req_wstrb) == StrbWidth) &&
    ($bits(bus.req_core_id) == CoreIDWidth) && ($bits(bus.rsp_rdata) == DataWidth) &&
    ($bits(bus.rsp_user) == UserWidth));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.req_valid && bus.req_dma |-> bus.req_amo == AMONone);

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.req_valid && !bus.req_ready |=> bus.req_valid &&
      $stable({bus.req_addr, bus.req_write, bus.req_amo, bus.req_wdata, bus.req_wstrb,
               bus.req_core_id, bus.req_is_core, bus.req_dma, bus.req_user}));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid);
endmodule
